// File: rtl/memory_island_pkg.sv
// Shared types and sizing helpers for the memory island bank arbiter.
package memory_island_pkg;

    // Owner of the access whose response is in flight.
    typedef enum logic {
        OWNER_NARROW = 1'b0,
        OWNER_WIDE   = 1'b1
    } owner_e;

    // $clog2 that never collapses to a zero-width vector.
    function automatic int clog2_min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/memory_island_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, with wrap-around.
module memory_island_rr_pick #(
    parameter int NumReq   = 4,
    parameter int IdxWidth = 2
) (
    input  logic [NumReq-1:0]   req,
    input  logic [IdxWidth-1:0] ptr,
    output logic [NumReq-1:0]   pick,
    output logic [IdxWidth-1:0] idx,
    output logic                valid
);

    always_comb begin : scan
        int cand;
        cand  = 0;
        pick  = '0;
        idx   = '0;
        valid = 1'b0;
        for (int off = 0; off < NumReq; off++) begin
            cand = (int'(ptr) + off) % NumReq;
            if (!valid && req[cand]) begin
                valid      = 1'b1;
                pick[cand] = 1'b1;
                idx        = IdxWidth'(cand);
            end
        end
    end

endmodule

// File: rtl/memory_island_bank_arb.sv
// Single-port bank arbiter: round-robin narrow ports plus a prioritised wide port,
// with a starvation escape for narrow traffic and owner-tracked response routing.
module memory_island_bank_arb
    import memory_island_pkg::*;
#(
    parameter int NumNarrow        = 4,
    parameter int BankAddrWidth    = 10,
    parameter int DataWidth        = 64,
    parameter int StrbWidth        = DataWidth / 8,
    parameter int WidePriorityWait = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NumNarrow-1:0]           narrow_req_i,
    output logic [NumNarrow-1:0]           narrow_gnt_o,
    input  logic [NumNarrow*BankAddrWidth-1:0] narrow_addr_i,
    input  logic [NumNarrow-1:0]           narrow_we_i,
    input  logic [NumNarrow*DataWidth-1:0] narrow_wdata_i,
    input  logic [NumNarrow*StrbWidth-1:0] narrow_strb_i,
    output logic [NumNarrow-1:0]           narrow_rvalid_o,
    output logic [DataWidth-1:0]           narrow_rdata_o,
    input  logic                           wide_req_i,
    output logic                           wide_gnt_o,
    input  logic [BankAddrWidth-1:0]       wide_addr_i,
    input  logic                           wide_we_i,
    input  logic [DataWidth-1:0]           wide_wdata_i,
    input  logic [StrbWidth-1:0]           wide_strb_i,
    output logic                           wide_rvalid_o,
    output logic [DataWidth-1:0]           wide_rdata_o,
    output logic                           bank_req_o,
    output logic                           bank_we_o,
    output logic [BankAddrWidth-1:0]       bank_addr_o,
    output logic [DataWidth-1:0]           bank_wdata_o,
    output logic [StrbWidth-1:0]           bank_strb_o,
    input  logic [DataWidth-1:0]           bank_rdata_i
);

    localparam int IdxWidth = clog2_min1(NumNarrow);
    localparam int CntWidth = clog2_min1(WidePriorityWait + 1);

    typedef struct packed {
        logic [BankAddrWidth-1:0] addr;
        logic                     we;
        logic [DataWidth-1:0]     wdata;
        logic [StrbWidth-1:0]     strb;
    } bank_req_t;

    bank_req_t narrow_bus [NumNarrow];
    bank_req_t wide_bus;
    bank_req_t sel_bus;

    logic [NumNarrow-1:0] narrow_pick;
    logic [IdxWidth-1:0]  narrow_idx;
    logic                 narrow_valid;
    logic                 force_narrow;
    logic                 wide_win;
    logic                 narrow_win;

    logic [CntWidth-1:0]  starve_cnt_reg, starve_cnt_next;
    logic [IdxWidth-1:0]  rr_ptr_reg, rr_ptr_next;
    logic                 rsp_valid_reg;
    owner_e               rsp_owner_reg;
    logic [IdxWidth-1:0]  rsp_idx_reg;

    for (genvar gi = 0; gi < NumNarrow; gi++) begin : g_narrow_bus
        assign narrow_bus[gi] = {narrow_addr_i[gi*BankAddrWidth +: BankAddrWidth],
                                 narrow_we_i[gi],
                                 narrow_wdata_i[gi*DataWidth +: DataWidth],
                                 narrow_strb_i[gi*StrbWidth +: StrbWidth]};
    end
    assign wide_bus = {wide_addr_i, wide_we_i, wide_wdata_i, wide_strb_i};

    memory_island_rr_pick #(
        .NumReq   (NumNarrow),
        .IdxWidth (IdxWidth)
    ) u_rr_pick (
        .req   (narrow_req_i),
        .ptr   (rr_ptr_reg),
        .pick  (narrow_pick),
        .idx   (narrow_idx),
        .valid (narrow_valid)
    );

    // With no wait configured the counter never saturates, so wide always wins.
    if (WidePriorityWait == 0) begin : g_no_force
        assign force_narrow = 1'b0;
    end else begin : g_force
        assign force_narrow = (starve_cnt_reg == CntWidth'(WidePriorityWait));
    end

    assign wide_win     = wide_req_i && !(narrow_valid && force_narrow);
    assign narrow_win   = narrow_valid && !wide_win;
    assign wide_gnt_o   = wide_win;
    assign narrow_gnt_o = narrow_win ? narrow_pick : '0;

    assign sel_bus      = wide_win   ? wide_bus :
                          narrow_win ? narrow_bus[narrow_idx] : '0;
    assign bank_req_o   = wide_win | narrow_win;
    assign bank_we_o    = sel_bus.we;
    assign bank_addr_o  = sel_bus.addr;
    assign bank_wdata_o = sel_bus.wdata;
    assign bank_strb_o  = sel_bus.strb;

    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (WidePriorityWait == 0 || !narrow_valid || narrow_win) begin
            starve_cnt_next = '0;
        end else if (wide_win && starve_cnt_reg != CntWidth'(WidePriorityWait)) begin
            starve_cnt_next = starve_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (narrow_win) begin
            rr_ptr_next = (narrow_idx == IdxWidth'(NumNarrow - 1)) ? '0 : narrow_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_cnt_reg <= '0;
            rr_ptr_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_owner_reg  <= OWNER_NARROW;
            rsp_idx_reg    <= '0;
        end else begin
            starve_cnt_reg <= starve_cnt_next;
            rr_ptr_reg     <= rr_ptr_next;
            rsp_valid_reg  <= bank_req_o;
            rsp_owner_reg  <= wide_win ? OWNER_WIDE : OWNER_NARROW;
            rsp_idx_reg    <= narrow_idx;
        end
    end

    assign wide_rvalid_o = rsp_valid_reg && (rsp_owner_reg == OWNER_WIDE);
    for (genvar gi = 0; gi < NumNarrow; gi++) begin : g_rvalid
        assign narrow_rvalid_o[gi] = rsp_valid_reg && (rsp_owner_reg == OWNER_NARROW)
                                     && (rsp_idx_reg == IdxWidth'(gi));
    end

    assign narrow_rdata_o = bank_rdata_i;
    assign wide_rdata_o   = bank_rdata_i;

endmodule

// File: tb/tb_memory_island_bank_arb.sv
// Scoreboard bench: three arbiters (WidePriorityWait 1, 3, 0) with private bank models,
// directed grant vectors checked inline, responses checked by a decoupled monitor.
module tb_memory_island_bank_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]   n_req [3];
    logic [39:0]  n_addr [3];
    logic [3:0]   n_we [3];
    logic [255:0] n_wdata [3];
    logic [31:0]  n_strb [3];
    logic         w_req [3];
    logic [9:0]   w_addr [3];
    logic         w_we [3];
    logic [63:0]  w_wdata [3];
    logic [7:0]   w_strb [3];

    logic [3:0]   n_gnt [3];
    logic [3:0]   n_rvalid [3];
    logic [63:0]  n_rdata [3];
    logic         w_gnt [3];
    logic         w_rvalid [3];
    logic [63:0]  w_rdata [3];
    logic         b_req [3];
    logic         b_we [3];
    logic [9:0]   b_addr [3];
    logic [63:0]  b_wdata [3];
    logic [7:0]   b_strb [3];
    logic [63:0]  b_rdata [3];
    int           cnt_mon [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int Wpw = (gi == 0) ? 1 : (gi == 1) ? 3 : 0;
        logic [63:0] mem [0:1023];
        logic [63:0] rdata_q;

        memory_island_bank_arb #(
            .NumNarrow        (4),
            .BankAddrWidth    (10),
            .DataWidth        (64),
            .WidePriorityWait (Wpw)
        ) u_dut (
            .clk_i           (clk),
            .rst_i           (rst),
            .narrow_req_i    (n_req[gi]),
            .narrow_gnt_o    (n_gnt[gi]),
            .narrow_addr_i   (n_addr[gi]),
            .narrow_we_i     (n_we[gi]),
            .narrow_wdata_i  (n_wdata[gi]),
            .narrow_strb_i   (n_strb[gi]),
            .narrow_rvalid_o (n_rvalid[gi]),
            .narrow_rdata_o  (n_rdata[gi]),
            .wide_req_i      (w_req[gi]),
            .wide_gnt_o      (w_gnt[gi]),
            .wide_addr_i     (w_addr[gi]),
            .wide_we_i       (w_we[gi]),
            .wide_wdata_i    (w_wdata[gi]),
            .wide_strb_i     (w_strb[gi]),
            .wide_rvalid_o   (w_rvalid[gi]),
            .wide_rdata_o    (w_rdata[gi]),
            .bank_req_o      (b_req[gi]),
            .bank_we_o       (b_we[gi]),
            .bank_addr_o     (b_addr[gi]),
            .bank_wdata_o    (b_wdata[gi]),
            .bank_strb_o     (b_strb[gi]),
            .bank_rdata_i    (b_rdata[gi])
        );

        assign cnt_mon[gi] = int'(u_dut.starve_cnt_reg);
        assign b_rdata[gi] = rdata_q;

        initial begin
            rdata_q = '0;
            for (int a = 0; a < 1024; a++) mem[a] = '0;
        end

        // Single-port bank model with byte enables and one-cycle read latency.
        always @(posedge clk) begin
            if (b_req[gi]) begin
                if (b_we[gi]) begin
                    for (int k = 0; k < 8; k++)
                        if (b_strb[gi][k]) mem[b_addr[gi]][k*8 +: 8] <= b_wdata[gi][k*8 +: 8];
                end else begin
                    rdata_q <= mem[b_addr[gi]];
                end
            end
        end
    end

    typedef struct {
        int          inst;
        logic [4:0]  vec;
        bit          chkd;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q [$];
    int checks   = 0;
    int failures = 0;

    // Response monitor: each observed rvalid vector must match the oldest expected owner.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                logic [4:0]  act;
                logic [63:0] rd;
                exp_t        e;
                act = {w_rvalid[i], n_rvalid[i]};
                if (act != 5'b0) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rsp_unexpected inst%0d: got rvalid %b, required none", i, act);
                    end else begin
                        e  = exp_q.pop_front();
                        rd = act[4] ? w_rdata[i] : n_rdata[i];
                        if (e.inst != i || act != e.vec || (e.chkd && rd != e.data)) begin
                            failures++;
                            $display("FAIL rsp inst%0d: got rvalid %b rdata %h, required inst%0d rvalid %b rdata %h",
                                     i, act, rd, e.inst, e.vec, e.data);
                        end else begin
                            $display("rsp inst%0d rvalid %b rdata %h", i, act, rd);
                        end
                    end
                end
            end
        end
    end

    task automatic idle_all();
        for (int i = 0; i < 3; i++) begin
            n_req[i] = '0; n_addr[i] = '0; n_we[i] = '0; n_wdata[i] = '0; n_strb[i] = '0;
            w_req[i] = 1'b0; w_addr[i] = '0; w_we[i] = 1'b0; w_wdata[i] = '0; w_strb[i] = '0;
        end
    endtask

    // One arbitration cycle: check the combinational grant, queue its expected response.
    task automatic cyc(input int inst, input logic [4:0] exp_g, input bit push, input bit chkd,
                       input logic [63:0] d, input int exp_cnt, input int exp_we);
        logic [4:0] g;
        exp_t       e;
        @(negedge clk);
        g = {w_gnt[inst], n_gnt[inst]};
        checks++;
        if (g !== exp_g || b_req[inst] !== (exp_g != 5'b0)) begin
            failures++;
            $display("FAIL gnt inst%0d: got gnt %b bank_req %b, required gnt %b", inst, g, b_req[inst], exp_g);
        end else begin
            $display("gnt inst%0d %b starve_cnt %0d", inst, g, cnt_mon[inst]);
        end
        if (exp_cnt >= 0) begin
            checks++;
            if (cnt_mon[inst] != exp_cnt) begin
                failures++;
                $display("FAIL starve_cnt inst%0d: got %0d, required %0d", inst, cnt_mon[inst], exp_cnt);
            end
        end
        if (exp_we >= 0) begin
            checks++;
            if (b_we[inst] !== exp_we[0] || b_addr[inst] !== 10'h005) begin
                failures++;
                $display("FAIL bank_cmd inst%0d: got we %b addr %h, required we %0d addr 005",
                         inst, b_we[inst], b_addr[inst], exp_we);
            end
        end
        if (push && exp_g != 5'b0) begin
            e.inst = inst; e.vec = exp_g; e.chkd = chkd; e.data = d;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic g1(input int inst, input logic [4:0] exp_g, input int exp_cnt);
        cyc(inst, exp_g, 1'b1, 1'b0, 64'h0, exp_cnt, -1);
    endtask

    logic [4:0] t2_g [8] = '{5'b10000, 5'b10000, 5'b10000, 5'b00001,
                             5'b10000, 5'b10000, 5'b10000, 5'b00001};
    int         t2_c [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    logic [4:0] t4_g [6] = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00010, 5'b01000};
    logic [4:0] t1_g [4] = '{5'b10000, 5'b00100, 5'b10000, 5'b00100};
    int         t1_c [4] = '{0, 1, 0, 1};

    initial begin
        idle_all();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({w_gnt[i], n_gnt[i]} != 5'b0 || {w_rvalid[i], n_rvalid[i]} != 5'b0
                || b_req[i] != 1'b0 || cnt_mon[i] != 0) begin
                failures++;
                $display("FAIL reset inst%0d: got gnt %b rvalid %b bank_req %b cnt %0d, required all 0",
                         i, {w_gnt[i], n_gnt[i]}, {w_rvalid[i], n_rvalid[i]}, b_req[i], cnt_mon[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Wait=1: wide and narrow[2] alternate.
        w_req[0] = 1'b1; w_addr[0] = 10'h010;
        n_req[0] = 4'b0100; n_addr[0][29:20] = 10'h020;
        for (int c = 0; c < 4; c++) cyc(0, t1_g[c], 1'b1, 1'b1, 64'h0, t1_c[c], -1);
        idle_all();
        cyc(0, 5'b00000, 1'b0, 1'b0, 64'h0, 0, -1);

        // Round robin 0,1,3 with wrap, no wide.
        n_req[2] = 4'b1011;
        for (int c = 0; c < 6; c++) g1(2, t4_g[c], 0);
        idle_all();
        cyc(2, 5'b00000, 1'b0, 1'b0, 64'h0, -1, -1);

        // Wait=0: wide always wins, counter stays 0; narrow[1] goes once wide drops.
        w_req[2] = 1'b1; n_req[2] = 4'b0010;
        for (int c = 0; c < 10; c++) g1(2, 5'b10000, 0);
        w_req[2] = 1'b0;
        g1(2, 5'b00010, 0);
        idle_all();

        // Wait=3: narrow[0] forced through every fourth cycle.
        w_req[1] = 1'b1; n_req[1] = 4'b0001;
        for (int c = 0; c < 8; c++) g1(1, t2_g[c], t2_c[c]);
        idle_all();
        cyc(1, 5'b00000, 1'b0, 1'b0, 64'h0, -1, -1);

        // Byte-masked write by narrow[1], then wide read of the same word.
        n_req[0] = 4'b0010; n_we[0] = 4'b0010; n_addr[0][19:10] = 10'h005;
        n_wdata[0][127:64] = 64'hDEADBEEF_CAFEF00D; n_strb[0][15:8] = 8'hF0;
        cyc(0, 5'b00010, 1'b1, 1'b0, 64'h0, -1, 1);
        idle_all();
        w_req[0] = 1'b1; w_addr[0] = 10'h005;
        cyc(0, 5'b10000, 1'b1, 1'b1, 64'hDEADBEEF_00000000, -1, 0);
        idle_all();
        cyc(0, 5'b00000, 1'b0, 1'b0, 64'h0, -1, -1);

        // Reset right after a grant drops its response and rewinds the pointer.
        n_req[0] = 4'b0100;
        cyc(0, 5'b00100, 1'b0, 1'b0, 64'h0, -1, -1);
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        checks++;
        if ({w_rvalid[0], n_rvalid[0]} != 5'b0) begin
            failures++;
            $display("FAIL rst_drop inst0: got rvalid %b, required 00000", {w_rvalid[0], n_rvalid[0]});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_req[0] = 4'b0101;
        g1(0, 5'b00001, -1);
        g1(0, 5'b00100, -1);
        idle_all();
        repeat (3) @(negedge clk);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL rsp_missing: got %0d responses outstanding, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
